// File: rtl/regfile_nxm_pkg.sv
// regfile_pkg: shared sizes and types for the regfile_nxm register file
package regfile_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int ZERO_REG  = 0;
  localparam int WCNT_W    = 16;
  typedef logic [DEF_WIDTH-1:0]         word_t;
  typedef logic [$clog2(DEF_DEPTH)-1:0] addr_t;
endpackage

// File: rtl/regfile_nxm_if.sv
// regfile_nxm_if: write port, two read ports and write counter of the register file
interface regfile_nxm_if import regfile_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic [WCNT_W-1:0] wr_count;
  modport master (output we, waddr, wdata, raddr_a, raddr_b, input rdata_a, rdata_b, wr_count);
  modport slave  (input we, waddr, wdata, raddr_a, raddr_b, output rdata_a, rdata_b, wr_count);
endinterface

// File: rtl/regfile_nxm_register_n.sv
// register_n: enable-gated WIDTH-bit register with asynchronous active-low clear
module register_n #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] val_d, val_q;
  always_comb val_d = en ? d : val_q;
  always_ff @(posedge clock or negedge clr_n)
    if (!clr_n) val_q <= '0;
    else        val_q <= val_d;
  assign q = val_q;
endmodule

// File: rtl/regfile_nxm.sv
// regfile_nxm: DEPTH x WIDTH register file, entry 0 hardwired to zero, 1 write / 2 async read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_nxm import regfile_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic           clock,
  input logic           clr_n,
  regfile_nxm_if.slave  bus
);
  logic [WIDTH-1:0]  regs [DEPTH];
  logic [WCNT_W-1:0] wr_count_d, wr_count_q;
  logic              wr_hit;
  assign regs[0] = '0;
  // one-hot write decode; entry 0 has no storage so index 0 never enables
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    register_n #(.WIDTH(WIDTH)) u_reg (
      .clock (clock),
      .clr_n (clr_n),
      .en    (bus.we && bus.waddr == ADDR_W'(i)),
      .d     (bus.wdata),
      .q     (regs[i])
    );
  end
  always_comb begin
    wr_hit     = bus.we && bus.waddr != ADDR_W'(ZERO_REG);
    wr_count_d = (wr_hit && wr_count_q != '1) ? wr_count_q + WCNT_W'(1) : wr_count_q;
`ifdef REGFILE_BYPASS_EN
    bus.rdata_a = (wr_hit && bus.raddr_a == bus.waddr) ? bus.wdata : regs[bus.raddr_a];
    bus.rdata_b = (wr_hit && bus.raddr_b == bus.waddr) ? bus.wdata : regs[bus.raddr_b];
`else
    bus.rdata_a = regs[bus.raddr_a];
    bus.rdata_b = regs[bus.raddr_b];
`endif
  end
  always_ff @(posedge clock or negedge clr_n)
    if (!clr_n) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile_nxm.sv
// tb_regfile_nxm: randomized and directed checks of regfile_nxm against an array model
module tb_regfile_nxm;
  import regfile_pkg::*;
  logic clock = 1'b0;
  logic clr_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  bit [31:0] mem [32];
  int   cnt = 0;
  regfile_nxm_if #(.WIDTH(32), .DEPTH(32)) bus ();
  regfile_nxm #(.WIDTH(32), .DEPTH(32)) dut (.clock(clock), .clr_n(clr_n), .bus(bus));
  always #5 clock = ~clock;
  initial begin
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr_a = '0; bus.raddr_b = '0;
  end
  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clock or negedge clr_n)
    if (!clr_n) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      cnt = 0;
    end else if (bus.we && bus.waddr != 0) begin
      mem[bus.waddr] = bus.wdata;
      if (cnt < 65535) cnt++;
    end
  function automatic word_t exp_rd(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (clr_n && bus.we && bus.waddr != 0 && int'(bus.waddr) == a) return bus.wdata;
`endif
    return mem[a];
  endfunction
  always @(negedge clock)
    if (chk_en) begin
      chk("rdata_a", bus.rdata_a, exp_rd(int'(bus.raddr_a)));
      chk("rdata_b", bus.rdata_b, exp_rd(int'(bus.raddr_b)));
      chk("wr_count", word_t'(bus.wr_count), word_t'(cnt));
    end
  task automatic cyc(input bit w, input int wa, input word_t wd, input int ra, input int rb);
    @(posedge clock); #1;
    bus.we = w; bus.waddr = 5'(wa); bus.wdata = wd; bus.raddr_a = 5'(ra); bus.raddr_b = 5'(rb);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1 clr_n = 1'b1;
    chk_en = 1'b1;
    cyc(1, 5, 32'hDEADBEEF, 5, 0);
    cyc(0, 0, 0, 5, 0);
    #2 chk("pre_reset_e5", bus.rdata_a, 32'hDEADBEEF);
    clr_n = 1'b0;
    #1 chk("reset_e5", bus.rdata_a, 32'h0);
    chk("reset_cnt", word_t'(bus.wr_count), 32'h0);
    cyc(0, 0, 0, 5, 0);
    clr_n = 1'b1;
    cyc(1, 7, 32'h12345678, 7, 7);
    cyc(0, 0, 0, 7, 7);
    #2 chk("e7_a", bus.rdata_a, 32'h12345678);
    chk("e7_b", bus.rdata_b, 32'h12345678);
    chk("e7_cnt", word_t'(bus.wr_count), 32'd1);
    cyc(1, 0, 32'hFFFFFFFF, 0, 7);
    cyc(0, 0, 0, 0, 7);
    #2 chk("zero_reg", bus.rdata_a, 32'h0);
    chk("zero_cnt", word_t'(bus.wr_count), 32'd1);
    cyc(1, 3, 32'h1, 3, 7);
    cyc(1, 3, 32'h2, 3, 7);
    #2
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_before", bus.rdata_a, 32'h2);
`else
    chk("rw_same_before", bus.rdata_a, 32'h1);
`endif
    chk("rw_other_port", bus.rdata_b, 32'h12345678);
    cyc(0, 3, 32'h2, 3, 7);
    #2 chk("rw_same_after", bus.rdata_a, 32'h2);
    chk("rw_cnt", word_t'(bus.wr_count), 32'd3);
    cyc(1, 9, 32'h99, 9, 0);
    repeat (4) cyc(0, 9, 32'hA5A5A5A5, 9, 0);
    #2 chk("we_low_e9", bus.rdata_a, 32'h99);
    chk("we_low_cnt", word_t'(bus.wr_count), 32'd4);
    for (int i = 1; i < 32; i++) cyc(1, i, word_t'(i), 0, 0);
    for (int i = 1; i < 32; i++) begin
      cyc(0, 0, 0, i, 32 - i);
      #2 chk("sweep", bus.rdata_a, word_t'(i));
    end
    chk("sweep_cnt", word_t'(bus.wr_count), 32'd35);
    for (int n = 0; n < 2000; n++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), word_t'($urandom),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      clr_n = ($urandom_range(0, 49) != 0);
    end
    cyc(0, 0, 0, 0, 0);
    clr_n = 1'b1;
    for (int n = 0; n < 65540; n++)
      cyc(1, int'($urandom_range(1, 31)), word_t'($urandom), int'($urandom_range(0, 31)), 0);
    cyc(0, 0, 0, 0, 0);
    #2 chk("saturate", word_t'(bus.wr_count), 32'h0000FFFF);
    @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_nxm.md
Name: regfile_nxm

Overview:
- Parametrised multi-register storage block. It generalises the single enable-gated 32-bit register into a DEPTH-entry by WIDTH-bit register file.
- One synchronous write port and two asynchronous read ports.
- Entry 0 is hardwired to zero.
- Sits between decode and execute in the RISC pipeline: sources rs1/rs2 operands, accepts writeback results.

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- clr_n  input  1  asynchronous, active-low reset; clears every register.
- we  input  1  write enable, sampled on rising clock.
- waddr  input  ADDR_W  write register index.
- wdata  input  WIDTH  write data.
- raddr_a  input  ADDR_W  read port A index.
- raddr_b  input  ADDR_W  read port B index.
- rdata_a  output  WIDTH  read port A data.
- rdata_b  output  WIDTH  read port B data.
- wr_count  output  16  saturating count of committed writes to nonzero entries (debug/perf).

Behaviour:
- Reset:
  - clr_n low immediately forces all entries 1..DEPTH-1 to 0 and wr_count to 0, independent of clock.
  - rdata_a and rdata_b therefore read 0 while in reset.
  - Deassertion takes effect asynchronously. The first write is accepted on the first rising edge with clr_n high.
- Write:
  - On a rising clock with clr_n high, we=1 and waddr!=0: entry[waddr] <= wdata.
  - Entry is visible on the read ports after that edge (1-cycle write latency without bypass).
- Write to entry 0: ignored; entry 0 always reads 0. The write does not increment wr_count.
- we=0: no entry changes; wr_count holds.
- Read:
  - Purely combinational: rdata_x = entry[raddr_x], zero-latency.
  - Both ports may read the same address simultaneously with no conflict.
- Read/write same address in the same cycle (feature disabled): read returns the old value until the edge, the new value after.
- wr_count:
  - Increments by 1 on each committed nonzero-address write.
  - Saturates at 16'hFFFF and does not wrap.
- Reset mid-operation: a write coinciding with clr_n low is lost; state is all-zero.
- Out-of-range addresses cannot occur, since DEPTH is a power of two.
- No X propagation: every entry has a defined reset value.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. When we=1, waddr!=0 and raddr_x==waddr, rdata_x returns wdata combinationally in the same cycle.
  - Applies independently to each read port.
  - raddr_x==0 still returns 0.
- Undefined: no forwarding; reads show the stored value only, as described under Behaviour.

Decomposition:
- Shared package regfile_pkg:
  - Default WIDTH and DEPTH constants.
  - ZERO_REG index constant (0).
  - wr_count width constant (16).
  - Typedef for a data word.
  - Typedef for a register address.
- One natural sub-module, register_n:
  - WIDTH-parametrised, enable-gated register with asynchronous active-low clear.
  - Instantiated DEPTH-1 times via generate.
  - Write-enable decode (one-hot from waddr, gated by we) and read muxes live in the top.

Test Plan:
- Reset: pulse clr_n low mid-cycle after writing entry 5 = 32'hDEADBEEF -> entry 5 and wr_count read 0 immediately, without a clock edge.
- Basic write/read: write entry 7 = 32'h12345678, then read with raddr_a=7, raddr_b=7 -> both return 32'h12345678 on the cycle after the edge; wr_count=1.
- Zero register: write entry 0 = 32'hFFFFFFFF -> raddr_a=0 returns 0; wr_count unchanged.
- Same-cycle read/write of entry 3 (old 32'h1, new 32'h2):
  - Without REGFILE_BYPASS_EN: rdata_a=32'h1 before the edge, 32'h2 after.
  - With REGFILE_BYPASS_EN: rdata_a=32'h2 in the same cycle; rdata_b on another address is unaffected.
- Enable low: we=0, waddr=9, wdata=32'hA5A5A5A5 for 4 cycles -> entry 9 stays at its previous value; wr_count holds.
- Saturation and sweep:
  - Write all entries 1..31 with their index, then read each back -> each returns its index.
  - Force 65540 nonzero writes -> wr_count=16'hFFFF.
